// File: rtl/cfa_pkg.sv
// Shared constants and types for the CFA gradient estimator.
package cfa_pkg;

  localparam int PIX_W      = 12;   // raw Bayer pixel width
  localparam int GRAD_W     = 8;    // gradient / weight output width
  localparam int GRAD_SHIFT = 4;    // scaling shift before saturation
  localparam int W_MID      = 128;  // weight for equal gradients
  localparam int GRAD_MAX   = 255;  // saturation ceiling

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [GRAD_W-1:0] grad_t;

endpackage

// File: rtl/cfa_absdiff.sv
// Combinational absolute difference |a - b| of two unsigned values.
module cfa_absdiff
  import cfa_pkg::*;
#(
  parameter int W = cfa_pkg::PIX_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // Subtract the smaller from the larger so the result never wraps.
  always_comb begin
    y = (a >= b) ? (a - b) : (b - a);
  end

endmodule

// File: rtl/cfa_gradients.sv
// Directional gradient estimator over a 5x5 Bayer window.
// Two-stage pipeline: stage 1 registers absolute differences, stage 2
// registers summed, scaled and saturated gradients plus direction weights.
// Optional macro CFA_GRADIENTS_WEIGHTS_EN enables the weight outputs;
// without it w_grad_hf / w_grad_vf are tied to 0.
module cfa_gradients
  import cfa_pkg::*;
#(
  parameter int PIX_W      = cfa_pkg::PIX_W,
  parameter int GRAD_W     = cfa_pkg::GRAD_W,
  parameter int GRAD_SHIFT = cfa_pkg::GRAD_SHIFT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
  input  logic [PIX_W-1:0]  p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
  input  logic [PIX_W-1:0]  p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
  input  logic [PIX_W-1:0]  p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
  input  logic [PIX_W-1:0]  p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2,
  output logic [GRAD_W-1:0] grad_hs,
  output logic [GRAD_W-1:0] grad_vs,
  output logic [GRAD_W-1:0] grad_hf,
  output logic [GRAD_W-1:0] grad_vf,
  output logic [GRAD_W-1:0] w_grad_hf,
  output logic [GRAD_W-1:0] w_grad_vf
);

  // Width of raw sums: five PIX_W terms need three extra bits.
  localparam int RAW_W = PIX_W + 3;
  // Second-derivative intermediate: 2*p - a - b spans a signed PIX_W+2 range.
  localparam int D2_W  = PIX_W + 2;

  // Window as array indexed [row+2][col+2].
  logic [PIX_W-1:0] pix [5][5];

  assign pix[0] = '{p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2};
  assign pix[1] = '{p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2};
  assign pix[2] = '{p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2};
  assign pix[3] = '{p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2};
  assign pix[4] = '{p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2};

  // The four corner pixels do not enter any gradient.
  logic unused_corners;
  assign unused_corners = ^{p_m2_m2, p_m2_p2, p_p2_m2, p_p2_p2};

  // Stage-1 combinational differences.
  logic [PIX_W-1:0] hd_d [5];   // |p(r,-1) - p(r,+1)| per row
  logic [PIX_W-1:0] vd_d [5];   // |p(-1,c) - p(+1,c)| per column
  logic [PIX_W:0]   hs2_d;      // |2p(0,0) - p(0,-2) - p(0,+2)|
  logic [PIX_W:0]   vs2_d;      // |2p(0,0) - p(-2,0) - p(+2,0)|

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_diff
      cfa_absdiff #(.W(PIX_W)) u_hd (.a(pix[gi][1]), .b(pix[gi][3]), .y(hd_d[gi]));
      cfa_absdiff #(.W(PIX_W)) u_vd (.a(pix[1][gi]), .b(pix[3][gi]), .y(vd_d[gi]));
    end
  endgenerate

  // Second-derivative terms evaluated in two's complement at full width.
  logic [D2_W-1:0] d2h_s, d2v_s;
  always_comb begin
    d2h_s = {1'b0, pix[2][2], 1'b0} - {2'b00, pix[2][0]} - {2'b00, pix[2][4]};
    d2v_s = {1'b0, pix[2][2], 1'b0} - {2'b00, pix[0][2]} - {2'b00, pix[4][2]};
    hs2_d = d2h_s[D2_W-1] ? PIX_W'(0) - d2h_s[PIX_W:0] : d2h_s[PIX_W:0];
    vs2_d = d2v_s[D2_W-1] ? PIX_W'(0) - d2v_s[PIX_W:0] : d2v_s[PIX_W:0];
  end

  logic [PIX_W-1:0] hd_q [5];
  logic [PIX_W-1:0] vd_q [5];
  logic [PIX_W:0]   hs2_q, vs2_q;
  logic             v1_q;

  // Stage 1: capture differences on a start strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      hs2_q <= '0;
      vs2_q <= '0;
      for (int i = 0; i < 5; i++) begin
        hd_q[i] <= '0;
        vd_q[i] <= '0;
      end
    end else begin
      v1_q <= start;
      if (start) begin
        hd_q  <= hd_d;
        vd_q  <= vd_d;
        hs2_q <= hs2_d;
        vs2_q <= vs2_d;
      end
    end
  end

  // Scale down, then clip to the gradient ceiling.
  function automatic logic [GRAD_W-1:0] sat_f(input logic [RAW_W-1:0] x);
    logic [RAW_W-1:0] s;
    s = x >> GRAD_SHIFT;
    if (s > RAW_W'(GRAD_MAX)) return GRAD_W'(GRAD_MAX);
    return s[GRAD_W-1:0];
  endfunction

  logic [RAW_W-1:0]  raw_hs_d, raw_vs_d, raw_hf_d, raw_vf_d;
  logic [GRAD_W-1:0] ghs_d, gvs_d, ghf_d, gvf_d;

  // Stage-2 combinational sums and saturation.
  always_comb begin
    raw_hs_d = RAW_W'(hd_q[2]) + RAW_W'(hs2_q);
    raw_vs_d = RAW_W'(vd_q[2]) + RAW_W'(vs2_q);
    raw_hf_d = '0;
    raw_vf_d = '0;
    for (int i = 0; i < 5; i++) begin
      raw_hf_d = raw_hf_d + RAW_W'(hd_q[i]);
      raw_vf_d = raw_vf_d + RAW_W'(vd_q[i]);
    end
    ghs_d = sat_f(raw_hs_d);
    gvs_d = sat_f(raw_vs_d);
    ghf_d = sat_f(raw_hf_d);
    gvf_d = sat_f(raw_vf_d);
  end

  logic [GRAD_W-1:0] ghs_q, gvs_q, ghf_q, gvf_q;

  // Stage 2: register gradients when stage 1 holds a valid window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghs_q <= '0;
      gvs_q <= '0;
      ghf_q <= '0;
      gvf_q <= '0;
    end else if (v1_q) begin
      ghs_q <= ghs_d;
      gvs_q <= gvs_d;
      ghf_q <= ghf_d;
      gvf_q <= gvf_d;
    end
  end

  assign grad_hs = ghs_q;
  assign grad_vs = gvs_q;
  assign grad_hf = ghf_q;
  assign grad_vf = gvf_q;

`ifdef CFA_GRADIENTS_WEIGHTS_EN
  int                w_hf_s, w_vf_s;
  logic [GRAD_W-1:0] w_hf_d, w_vf_d, w_hf_q, w_vf_q;

  // Weights favour the direction with the smaller gradient, clamped 0..max.
  always_comb begin
    w_hf_s = W_MID + int'(gvf_d) - int'(ghf_d);
    w_vf_s = W_MID + int'(ghf_d) - int'(gvf_d);
    w_hf_d = (w_hf_s < 0) ? '0 : (w_hf_s > GRAD_MAX) ? GRAD_W'(GRAD_MAX) : GRAD_W'(w_hf_s);
    w_vf_d = (w_vf_s < 0) ? '0 : (w_vf_s > GRAD_MAX) ? GRAD_W'(GRAD_MAX) : GRAD_W'(w_vf_s);
  end

  // Weights share the stage-2 enable with the gradients.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_hf_q <= '0;
      w_vf_q <= '0;
    end else if (v1_q) begin
      w_hf_q <= w_hf_d;
      w_vf_q <= w_vf_d;
    end
  end

  assign w_grad_hf = w_hf_q;
  assign w_grad_vf = w_vf_q;
`else
  assign w_grad_hf = '0;
  assign w_grad_vf = '0;
`endif

endmodule

// File: tb/tb_cfa_gradients.sv
// Table-driven scoreboard bench for cfa_gradients.
module tb_cfa_gradients;

  typedef struct packed {
    logic [7:0] hs, vs, hf, vf, wh, wv;
  } res_t;

  typedef struct {
    int   base;
    int   sc;     // per-column step
    int   sr;     // per-row step
    bit   ovr;    // override the centre pixel
    int   cen;
    res_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] pix [5][5];
  logic [7:0]  grad_hs, grad_vs, grad_hf, grad_vf, w_grad_hf, w_grad_vf;

  always #5 clk = ~clk;

  cfa_gradients dut (
    .clk(clk), .rst(rst), .start(start),
    .p_m2_m2(pix[0][0]), .p_m2_m1(pix[0][1]), .p_m2_p0(pix[0][2]), .p_m2_p1(pix[0][3]), .p_m2_p2(pix[0][4]),
    .p_m1_m2(pix[1][0]), .p_m1_m1(pix[1][1]), .p_m1_p0(pix[1][2]), .p_m1_p1(pix[1][3]), .p_m1_p2(pix[1][4]),
    .p_p0_m2(pix[2][0]), .p_p0_m1(pix[2][1]), .p_p0_p0(pix[2][2]), .p_p0_p1(pix[2][3]), .p_p0_p2(pix[2][4]),
    .p_p1_m2(pix[3][0]), .p_p1_m1(pix[3][1]), .p_p1_p0(pix[3][2]), .p_p1_p1(pix[3][3]), .p_p1_p2(pix[3][4]),
    .p_p2_m2(pix[4][0]), .p_p2_m1(pix[4][1]), .p_p2_p0(pix[4][2]), .p_p2_p1(pix[4][3]), .p_p2_p2(pix[4][4]),
    .grad_hs(grad_hs), .grad_vs(grad_vs), .grad_hf(grad_hf), .grad_vf(grad_vf),
    .w_grad_hf(w_grad_hf), .w_grad_vf(w_grad_vf)
  );

  int   n_vec  = 0;
  int   n_fail = 0;
  res_t sb_q[$];
  res_t last;
  bit   s1 = 1'b0;   // bench copy of "a window was sampled on the previous edge"
  vec_t tab [8];

  function automatic res_t mk(int hs, int vs, int hf, int vf, int wh, int wv);
    res_t r;
    r.hs = 8'(hs); r.vs = 8'(vs); r.hf = 8'(hf); r.vf = 8'(vf);
`ifdef CFA_GRADIENTS_WEIGHTS_EN
    r.wh = 8'(wh); r.wv = 8'(wv);
`else
    r.wh = 8'(wh * 0); r.wv = 8'(wv * 0);
`endif
    return r;
  endfunction

  task automatic set_win(input vec_t v);
    int val;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        val = v.base + v.sc * (c - 2) + v.sr * (r - 2);
        if (v.ovr && r == 2 && c == 2) val = v.cen;
        pix[r][c] = 12'(val);
      end
    end
  endtask

  task automatic check(input string tag);
    res_t act;
    act = {grad_hs, grad_vs, grad_hf, grad_vf, w_grad_hf, w_grad_vf};
    n_vec++;
    if (act !== last) begin
      n_fail++;
      $display("FAIL %s: got hs=%0d vs=%0d hf=%0d vf=%0d whf=%0d wvf=%0d, expected hs=%0d vs=%0d hf=%0d vf=%0d whf=%0d wvf=%0d",
               tag, act.hs, act.vs, act.hf, act.vf, act.wh, act.wv,
               last.hs, last.vs, last.hf, last.vf, last.wh, last.wv);
    end else begin
      $display("ok   %s: hs=%0d vs=%0d hf=%0d vf=%0d whf=%0d wvf=%0d",
               tag, act.hs, act.vs, act.hf, act.vf, act.wh, act.wv);
    end
  endtask

  // One clock: drive start, advance, retire a result if one is due, compare.
  task automatic tick(input bit st, input string tag);
    bit due;
    start = st;
    @(posedge clk);
    due = s1;
    s1  = st && !rst;
    #1;
    if (due) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL %s: result due but scoreboard empty", tag);
      end else begin
        last = sb_q.pop_front();
      end
    end
    check(tag);
  endtask

  task automatic issue(input int idx, input string tag);
    set_win(tab[idx]);
    sb_q.push_back(tab[idx].exp);
    tick(1'b1, tag);
  endtask

  initial begin
    //            base  sc   sr  ovr cen       hs   vs   hf   vf   whf  wvf
    tab[0] = '{100,    0,   0, 0,   0, mk(  0,   0,   0,   0, 128, 128)};  // flat
    tab[1] = '{1000,  64,   0, 0,   0, mk(  8,   0,  40,   0,  88, 168)};  // horizontal ramp
    tab[2] = '{0,      0,   0, 1,4095, mk(255, 255,   0,   0, 128, 128)};  // bright centre
    tab[3] = '{1000,   0,  64, 0,   0, mk(  0,   8,   0,  40, 168,  88)};  // vertical ramp
    tab[4] = '{1000, 300,   0, 0,   0, mk( 37,   0, 187,   0,   0, 255)};  // weight clamps
    tab[5] = '{4095,   0,   0, 1,   0, mk(255, 255,   0,   0, 128, 128)};  // dark centre
    tab[6] = '{2000,  16,  32, 0,   0, mk(  2,   4,  10,  20, 138, 118)};  // diagonal ramp
    tab[7] = '{500,    3,   0, 0,   0, mk(  0,   0,   1,   0, 127, 129)};  // shift truncation

    set_win(tab[0]);
    last = '0;
    #3;
    check("reset_state");
    tick(1'b0, "reset_held");
    rst = 1'b0;

    // Isolated windows, each followed by an idle cycle.
    for (int i = 0; i < 8; i++) begin
      issue(i, $sformatf("single%0d_issue", i));
      tick(1'b0, $sformatf("single%0d_result", i));
    end

    // Hold: window 2 sampled, then inputs change with start low.
    issue(1, "hold_issue");
    set_win(tab[2]);
    for (int k = 0; k < 12; k++) tick(1'b0, $sformatf("hold%0d", k));

    // Back-to-back windows with no bubble.
    for (int i = 0; i < 8; i++) issue(i, $sformatf("b2b%0d", i));
    tick(1'b0, "b2b_drain");
    tick(1'b0, "b2b_idle");

    // Reset between stage-1 and stage-2 edges of an in-flight window.
    issue(1, "rst_issue");
    #3;
    rst = 1'b1;
    #1;
    sb_q.delete();
    s1   = 1'b0;
    last = '0;
    check("rst_async_clear");
    tick(1'b0, "rst_held");
    #3;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick(1'b0, $sformatf("post_rst%0d", k));

    // First window after release appears on schedule.
    issue(6, "post_rst_issue");
    tick(1'b0, "post_rst_result");
    tick(1'b0, "post_rst_hold");

    n_vec++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cfa_gradients.md
# cfa_gradients

Directional gradient estimator for the colour-filter-array (CFA) demosaicing datapath. It takes a 5x5 window of 12-bit raw Bayer pixels centred on the current pixel. It produces:
- simple horizontal/vertical gradients (equations 4 and 5),
- full-window horizontal/vertical gradients,
- a pair of complementary 8-bit direction weights used by the downstream interpolator.

## Interface
Parameters:
- PIX_W, 12, raw pixel width
- GRAD_W, 8, gradient/weight output width
- GRAD_SHIFT, 4, right-shift applied to raw gradient sums before saturation

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  window-valid strobe; the window is sampled on a clk edge where start=1
- p_R_C  in  PIX_W each  25 pixel inputs
  - R,C each take a value in {m2,m1,p0,p1,p2}, meaning offsets −2..+2.
  - R is the row offset and C is the column offset from the centre p_p0_p0.
- grad_hs  out  GRAD_W  simple horizontal gradient
- grad_vs  out  GRAD_W  simple vertical gradient
- grad_hf  out  GRAD_W  full-window horizontal gradient
- grad_vf  out  GRAD_W  full-window vertical gradient
- w_grad_hf  out  GRAD_W  horizontal interpolation weight
- w_grad_vf  out  GRAD_W  vertical interpolation weight

## Operation
Notation: p(r,c) is the pixel at row offset r, column offset c. |x| is the absolute value, computed exactly at full width with no wrap. sat(x) = min(255, x >> GRAD_SHIFT).

Gradients:
- raw_hs = |p(0,−1) − p(0,+1)| + |2·p(0,0) − p(0,−2) − p(0,+2)|
  - Equation 4; 14-bit unsigned.
  - The second term is a signed 14-bit intermediate.
- raw_vs = |p(−1,0) − p(+1,0)| + |2·p(0,0) − p(−2,0) − p(+2,0)|
  - Equation 5; same widths as raw_hs.
- raw_hf = Σ over r=−2..+2 of |p(r,−1) − p(r,+1)|; 15-bit.
- raw_vf = Σ over c=−2..+2 of |p(−1,c) − p(+1,c)|; 15-bit.
- grad_xx = sat(raw_xx) for each of hs, vs, hf, vf.

Weights (signed arithmetic, clamped to 0..255):
- w_grad_hf = clamp(128 + grad_vf − grad_hf)
- w_grad_vf = clamp(128 + grad_hf − grad_vf)
- A lower gradient in one direction gives a higher weight in that direction.
- Equal gradients give 128 on both weights.

## Timing
Two-stage pipeline, throughput one window per cycle.

- Stage 1: on a clk edge with start=1, register all absolute differences and a stage-1 valid flag.
  - The window need only be stable around that edge.
- Stage 2: on the next edge with the stage-1 valid flag set, register all six outputs (sums, shift, saturation, weights).
- Latency: outputs reflect a window 2 edges after the edge that sampled it.
- start=0: no new sample; outputs hold their last value indefinitely.
- Back-to-back start: consecutive windows appear on consecutive cycles with no bubble.
- Reset, asserted at any time including mid-pipeline:
  - All outputs, including both weights, go to 0 immediately.
  - Both valid flags clear and in-flight windows are discarded.
  - The first result after reset release appears 2 edges after the first start.

## Configuration
- Macro: CFA_GRADIENTS_WEIGHTS_EN.
- Defined: weight logic is present and w_grad_hf / w_grad_vf behave as specified.
- Undefined: weight logic is removed.
  - w_grad_hf and w_grad_vf are constant 0, including after reset.
  - The four gradient outputs are unaffected.

## Structure
- Shared package cfa_pkg holds:
  - PIX_W, GRAD_W, GRAD_SHIFT
  - W_MID=128, GRAD_MAX=255
  - the pixel and gradient typedefs
- One sub-module, cfa_absdiff: combinational |a−b| of two unsigned PIX_W values.
  - Instantiated for every pixel-pair difference.
  - The second-derivative terms stay inline.

## Test plan
1. Flat window, all pixels 100, start pulsed once -> 2 edges later all four gradients 0, w_grad_hf=128, w_grad_vf=128.
2. Horizontal ramp p(r,c)=1000+64·c -> grad_hs=8, grad_vs=0, grad_hf=40, grad_vf=0, w_grad_hf=88, w_grad_vf=168.
3. Saturation: centre 4095, all others 0 -> grad_hs=255, grad_vs=255, grad_hf=0, grad_vf=0, weights 128/128.
4. Hold and latency: apply test 2's window with start=1 for one cycle, then change the inputs to test 3's window with start=0 -> outputs stay at test 2's values for 10+ cycles.
5. Pipelining: start held high over windows 1, 2, 3 on consecutive edges -> outputs equal test 1, test 2, then test 3 results on consecutive cycles.
6. Reset mid-operation: assert rst between the stage-1 and stage-2 edges of a window -> all outputs 0 at once; after release with start=0, outputs remain 0.
